// File: rtl/aesha_loader_pkg.sv
// rtl/aesha_loader_pkg.sv - shared state, phase and mode encodings for the AESHA input loader
package aesha_loader_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_KEY  = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_WAIT      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_KEY  = 2'd1;
    localparam logic [1:0] PHASE_DATA = 2'd2;
    localparam logic [1:0] PHASE_CORE = 2'd3;

    localparam logic MODE_AES    = 1'b0;
    localparam logic MODE_KECCAK = 1'b1;

    function automatic logic [1:0] phase_of(input logic [2:0] st);
        case (st)
            ST_LOAD_KEY:       phase_of = PHASE_KEY;
            ST_LOAD_DATA:      phase_of = PHASE_DATA;
            ST_ISSUE, ST_WAIT: phase_of = PHASE_CORE;
            default:           phase_of = PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/aesha_strobe_sync.sv
// rtl/aesha_strobe_sync.sv - write strobe synchroniser and edge detector; optional debouncer under AESHA_LOADER_DEBOUNCE_EN
module aesha_strobe_sync #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic write_event
);

`ifdef AESHA_LOADER_DEBOUNCE_EN
    localparam int DB_ENABLE = 1;
`else
    localparam int DB_ENABLE = 0;
`endif
    localparam int DB_CYCLES = DEBOUNCE_CYCLES * DB_ENABLE;

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= strobe;
            sync_2 <= sync_1;
        end
    end

    generate
        if (DB_CYCLES > 0) begin : g_debounce
            localparam int CW = $clog2(DB_CYCLES + 1);
            logic [CW-1:0] stable_cnt;
            logic          filtered;

            // The filtered level follows only after DB_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_cnt <= '0;
                    filtered   <= 1'b0;
                end else if (sync_2 == filtered) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
                    stable_cnt <= '0;
                    filtered   <= sync_2;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
            assign level = filtered;
        end else begin : g_direct
            assign level = sync_2;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign write_event = level & ~level_prev;

endmodule

// File: rtl/aesha_input_loader.sv
// rtl/aesha_input_loader.sv - assembles AESHA key/data operands from manually entered bytes and starts the core
// Optional write-strobe debouncer: AESHA_LOADER_DEBOUNCE_EN
import aesha_loader_pkg::*;

module aesha_input_loader #(
    parameter int KEY_BYTES       = 16,
    parameter int DATA_BYTES      = 64,
    parameter int AES_DATA_BYTES  = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [7:0]              i_byte,
    input  logic                    i_wr,
    input  logic                    i_clear,
    input  logic                    i_aes_or_keccak,
    input  logic                    i_enc_or_dec,
    input  logic                    i_busy,
    input  logic                    i_done,
    output logic [8*KEY_BYTES-1:0]  o_key,
    output logic [8*DATA_BYTES-1:0] o_data,
    output logic                    o_aes_or_keccak,
    output logic                    o_enc_or_dec,
    output logic                    o_start,
    output logic [6:0]              o_count,
    output logic [1:0]              o_phase,
    output logic                    o_overrun
);

    localparam int         KW          = 8 * KEY_BYTES;
    localparam int         DW          = 8 * DATA_BYTES;
    localparam logic [6:0] KEY_LAST    = 7'(KEY_BYTES);
    localparam logic [6:0] DATA_LAST_A = 7'(AES_DATA_BYTES);
    localparam logic [6:0] DATA_LAST_K = 7'(DATA_BYTES);

    logic [2:0] state;
    logic       wr_event;
    logic [6:0] count_next;
    logic [6:0] data_last;

    aesha_strobe_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strobe_sync (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .strobe     (i_wr),
        .write_event(wr_event)
    );

    assign count_next = o_count + 7'd1;
    assign data_last  = (o_aes_or_keccak == MODE_AES) ? DATA_LAST_A : DATA_LAST_K;
    assign o_phase    = phase_of(state);
    // Start is combinational so a busy core delays it without losing a cycle once busy drops.
    assign o_start    = (state == ST_ISSUE) && !i_busy && !i_clear;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= ST_IDLE;
            o_key           <= '0;
            o_data          <= '0;
            o_aes_or_keccak <= 1'b0;
            o_enc_or_dec    <= 1'b0;
            o_count         <= '0;
            o_overrun       <= 1'b0;
        end else if (i_clear) begin
            state     <= ST_IDLE;
            o_key     <= '0;
            o_data    <= '0;
            o_count   <= '0;
            o_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (wr_event) begin
                        o_aes_or_keccak <= i_aes_or_keccak;
                        o_enc_or_dec    <= i_enc_or_dec;
                        o_count         <= 7'd1;
                        if (i_aes_or_keccak == MODE_KECCAK) begin
                            o_key  <= '0;
                            o_data <= DW'(i_byte);
                            state  <= ST_LOAD_DATA;
                        end else begin
                            o_key  <= KW'(i_byte);
                            o_data <= '0;
                            state  <= ST_LOAD_KEY;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (wr_event) begin
                        o_key <= {o_key[KW-9:0], i_byte};
                        if (count_next == KEY_LAST) begin
                            o_count <= '0;
                            state   <= ST_LOAD_DATA;
                        end else begin
                            o_count <= count_next;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    // AES data stays in the low field because the upper bits were cleared at load start.
                    if (wr_event) begin
                        o_data  <= {o_data[DW-9:0], i_byte};
                        o_count <= count_next;
                        if (count_next == data_last) begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (wr_event) begin
                        o_overrun <= 1'b1;
                    end
                    if (!i_busy) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wr_event) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_done) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aesha_input_loader.md
Name: aesha_input_loader

Overview:
- Input-side counterpart of the AESHA board wrapper's output display path.
- Assembles the AESHA_top key and data operands from a sequence of manually entered bytes (8 slide switches plus a write strobe), latches the mode bits, and issues a one-cycle start to the core.
- Waits for the core's done signal before accepting a new operand set.
- Sits between the board I/O and AESHA_top, replacing the hard-wired zero key and data.

Parameters:
- KEY_BYTES, 16, number of key bytes loaded in AES mode (key width = 8*KEY_BYTES).
- DATA_BYTES, 64, number of data bytes loaded in Keccak mode (data width = 8*DATA_BYTES).
- AES_DATA_BYTES, 16, number of data bytes loaded in AES mode.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required on the write strobe; used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_byte  in  8  byte value to store; held stable by the user while i_wr is high.
- i_wr  in  1  raw asynchronous write strobe, active high.
- i_clear  in  1  synchronous abort/clear, active high.
- i_aes_or_keccak  in  1  0 = AES, 1 = Keccak; sampled at the first byte of a load.
- i_enc_or_dec  in  1  0 = encrypt, 1 = decrypt; sampled with i_aes_or_keccak.
- i_busy  in  1  core busy.
- i_done  in  1  core done pulse/level.
- o_key  out  8*KEY_BYTES  key operand to the core.
- o_data  out  8*DATA_BYTES  data operand to the core.
- o_aes_or_keccak  out  1  latched mode.
- o_enc_or_dec  out  1  latched direction.
- o_start  out  1  one-cycle start pulse.
- o_count  out  7  bytes stored in the current phase, for display.
- o_phase  out  2  0 IDLE/DONE, 1 key, 2 data, 3 core running.
- o_overrun  out  1  sticky: a write arrived while the core was running.

Behaviour:
- Reset (async, i_reset_n low): all outputs and registers 0, state IDLE.
- Strobe path: i_wr passes through a 2-flop synchroniser, then a rising-edge detector. A write event occurs on the 3rd i_clk rising edge after i_wr rises. i_byte is sampled on the event cycle.
- Byte order: the first byte of a phase goes to the MSB of that field. Each subsequent byte shifts the field left by 8 and enters at the LSBs.
- AES data fills o_data[8*AES_DATA_BYTES-1:0]; the upper o_data bits are 0.
- Keccak mode: o_key = 0.
- States:
  - IDLE: on a write event, clear o_key/o_data, latch the mode bits, store the byte, count = 1. Go to LOAD_KEY (AES) or LOAD_DATA (Keccak).
  - LOAD_KEY: each event stores a byte and increments count. On the event making count = KEY_BYTES, go to LOAD_DATA with count = 0.
  - LOAD_DATA: same rule. The last byte is AES_DATA_BYTES (AES) or DATA_BYTES (Keccak); on it go to ISSUE.
  - ISSUE: if !i_busy, o_start = 1 for exactly this cycle, then go to WAIT. If i_busy, stay with o_start = 0.
  - WAIT: on i_done = 1, go to DONE.
  - DONE: o_key/o_data/mode held for display. A write event behaves as in IDLE and starts a new load.
- Writes in ISSUE or WAIT are ignored and set o_overrun. o_overrun is cleared only by i_clear or reset.
- i_clear (any state, highest priority after reset): state IDLE, count 0, o_key/o_data/o_overrun 0, o_start 0.
  - In WAIT the core is not aborted; its later i_done is ignored.
- A simultaneous i_clear and write event: the clear wins and the byte is dropped.
- o_phase: IDLE/DONE = 0, LOAD_KEY = 1, LOAD_DATA = 2, ISSUE/WAIT = 3.
- Mode inputs changing mid-load have no effect until the next load.

Optional Feature:
- Macro: AESHA_LOADER_DEBOUNCE_EN.
- Defined: the synchronised strobe feeds a debouncer. The filtered level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; the edge detector uses the filtered level. This adds DEBOUNCE_CYCLES cycles of latency, and bounces shorter than DEBOUNCE_CYCLES produce no event.
- Undefined: no debouncer, and DEBOUNCE_CYCLES is unused.

Decomposition:
- Package aesha_loader_pkg: state enum (IDLE, LOAD_KEY, LOAD_DATA, ISSUE, WAIT, DONE), phase encoding constants, MODE_AES = 0 / MODE_KECCAK = 1.
- One sub-module: aesha_strobe_sync. It contains the 2-flop synchroniser, the optional debouncer and the edge detector, and outputs a one-cycle write event.

Test Plan:
- AES load: mode 0, write bytes 00..0F, then 10..1F.
  -> o_key = 128'h000102...0F, o_data[127:0] = 128'h101112...1F, upper data 0.
  -> o_start pulses exactly 1 cycle with i_busy = 0; o_phase sequence 1, 2, 3.
- Keccak load: mode 1, write 64 bytes A0+i (i = 0..63).
  -> o_key = 0, o_data[511:504] = A0, o_data[7:0] = DF.
  -> hold i_busy = 1 for 5 cycles in ISSUE: o_start is delayed until i_busy = 0.
- Overrun: during WAIT write byte 55.
  -> o_data unchanged, o_overrun = 1.
  -> after i_done, state DONE; o_overrun stays 1 until i_clear.
- Clear mid-load: after 7 key bytes assert i_clear.
  -> o_count = 0, o_key = 0, o_phase = 0.
  -> a simultaneous write event is dropped; the next byte starts a fresh load.
- Reset mid-load: drop i_reset_n asynchronously between clock edges.
  -> all outputs 0 immediately; the load restarts cleanly after release.
- With AESHA_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16:
  -> a 5-cycle high glitch on i_wr produces no write.
  -> a 20-cycle pulse produces exactly one write.
